bikelight_ctrl: RTL and testbench
=================================

BIKELIGHT_CTRL -- requirements
Module: bikelight_ctrl

Interface
REQ-001 The block SHALL have parameter LONG_T, default 16, meaning hold cycles after btn_rise that qualify a long press (>=2).
REQ-002 The block SHALL have parameter TIMEOUT, default 1024, meaning idle cycles in a lit mode before auto-off (>=2).
REQ-003 The block SHALL have parameter BLINK_W, default 4, meaning blink counter width; the blink period is 2^BLINK_W cycles.
REQ-004 The block SHALL have parameter PWM_W, default 2, meaning dim PWM counter width; the PWM period is 2^PWM_W cycles.
REQ-005 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 Port btn_rise, input, 1 bit: one-cycle pulse from the input conditioner on button press.
REQ-008 Port btn_fall, input, 1 bit: one-cycle pulse from the input conditioner on button release.
REQ-009 Port dim_duty, input, PWM_W bits: DIM-mode on-count per PWM period.
REQ-010 Port led, output, 1 bit: lamp drive.
REQ-011 Port mode, output, 2 bits: current mode, OFF=00, ON=01, BLINK=10, DIM=11.
REQ-012 Port long_press, output, 1 bit: one-cycle pulse when a long press is recognised.

Function
REQ-013 The mode FSM SHALL advance OFF->ON->BLINK->DIM->OFF by one step per short press, updating mode on the clock edge after the qualifying btn_fall.
REQ-014 On btn_rise the block SHALL set an internal pressed flag, clear hold_cnt to 0 and clear long_flag.
REQ-015 While pressed=1, hold_cnt SHALL increment by 1 per cycle and saturate at LONG_T-1.
REQ-016 When pressed=1, long_flag=0 and hold_cnt==LONG_T-1, the next edge SHALL force mode to OFF from any mode, assert long_press for exactly one cycle and set long_flag.
REQ-017 A btn_fall with pressed=1 and long_flag=0 SHALL be a short press; a btn_fall with long_flag=1 SHALL clear pressed without advancing the mode.
REQ-018 A btn_fall while pressed=0 SHALL be ignored.
REQ-019 If btn_rise and btn_fall assert in the same cycle, btn_rise SHALL take priority and btn_fall SHALL be ignored.
REQ-020 idle_cnt SHALL increment each cycle while mode!=OFF, and SHALL clear to 0 on btn_rise, on any mode change, and while mode=OFF.
REQ-021 When idle_cnt==TIMEOUT-1 and pressed=0, the next edge SHALL set mode to OFF.
REQ-022 While pressed=1, timeout SHALL be suppressed.
REQ-023 If a short press and a timeout coincide, the short press SHALL win.
REQ-024 If a long-press trigger and a short press coincide, the long press SHALL win.
REQ-025 blink_cnt (BLINK_W bits) SHALL free-run with wrap-around and SHALL clear to 0 on the edge that enters BLINK.
REQ-026 pwm_cnt (PWM_W bits) SHALL free-run with wrap-around.
REQ-027 led SHALL equal: 0 in OFF; 1 in ON; blink_cnt[BLINK_W-1] in BLINK; (pwm_cnt < dim_duty) in DIM.
REQ-028 led SHALL be a combinational decode of registered state only, with no input-to-output combinational path.
REQ-029 dim_duty=0 SHALL give led constantly 0 in DIM; the maximum dim_duty value SHALL give (2^PWM_W-1)/2^PWM_W duty (75% at default).

Reset
REQ-030 While rst_n=0 at a clock edge, the block SHALL clear mode to OFF and clear pressed, long_flag, hold_cnt, idle_cnt, blink_cnt and pwm_cnt to 0.
REQ-031 During reset, led and long_press SHALL read 0 from the first edge with rst_n=0.
REQ-032 Reset asserted mid-press SHALL discard the press, so a following btn_fall is ignored.
REQ-033 btn_rise and btn_fall SHALL be ignored in any cycle where rst_n=0.

Verification
REQ-034 Bench SHALL cover: 4 short presses (rise, 3 cycles, fall) from reset -> mode 01, 10, 11, 00, each changing one cycle after fall.
REQ-035 Bench SHALL cover: in ON, hold for LONG_T=16 cycles -> long_press pulses once, mode=00; the later fall leaves mode 00.
REQ-036 Bench SHALL cover: in ON, no input for 1024 cycles -> mode=00 at the idle_cnt==1023 +1 edge; a press at cycle 1000 restarts the count.
REQ-037 Bench SHALL cover: BLINK with BLINK_W=4 -> led low 8 cycles then high 8 cycles, repeating from entry.
REQ-038 Bench SHALL cover: DIM with dim_duty=3, PWM_W=2 -> led pattern 1,1,1,0 repeating; dim_duty=0 -> led stays 0.
REQ-039 Bench SHALL cover: rst_n low for 1 cycle mid-press in DIM -> mode=00, led=0; the following btn_fall is ignored; simultaneous rise+fall -> no advance.

Source files
------------

// File: rtl/bikelight_ctrl.sv
// Bicycle lamp controller. Short presses step the mode OFF->ON->BLINK->DIM->OFF.
// A long press or an idle timeout forces the lamp OFF.
module bikelight_ctrl #(
  parameter int LONG_T  = 16,
  parameter int TIMEOUT = 1024,
  parameter int BLINK_W = 4,
  parameter int PWM_W   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_rise,
  input  logic             btn_fall,
  input  logic [PWM_W-1:0] dim_duty,
  output logic             led,
  output logic [1:0]       mode,
  output logic             long_press
);

  localparam int HOLD_W = (LONG_T > 2) ? $clog2(LONG_T) : 1;
  localparam int IDLE_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_T - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_DIM   = 2'b11
  } mode_e;

  mode_e              mode_q;
  logic               pressed_q;
  logic               long_flag_q;
  logic               long_press_q;
  logic [HOLD_W-1:0]  hold_cnt_q;
  logic [IDLE_W-1:0]  idle_cnt_q;
  logic [BLINK_W-1:0] blink_cnt_q;
  logic [PWM_W-1:0]   pwm_cnt_q;
  logic [PWM_W-1:0]   duty_q;

  mode_e mode_adv_d;
  logic  long_trig;
  logic  timeout_hit;

  assign mode_adv_d  = mode_e'(mode_q + 2'd1);
  assign long_trig   = pressed_q & ~long_flag_q & (hold_cnt_q == HOLD_MAX);
  assign timeout_hit = ~pressed_q & (mode_q != MODE_OFF) & (idle_cnt_q == IDLE_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q       <= MODE_OFF;
      pressed_q    <= 1'b0;
      long_flag_q  <= 1'b0;
      long_press_q <= 1'b0;
      hold_cnt_q   <= '0;
      idle_cnt_q   <= '0;
      blink_cnt_q  <= '0;
      pwm_cnt_q    <= '0;
      duty_q       <= '0;
    end else begin
      long_press_q <= 1'b0;
      duty_q       <= dim_duty;
      pwm_cnt_q    <= pwm_cnt_q + PWM_W'(1);
      blink_cnt_q  <= blink_cnt_q + BLINK_W'(1);

      // Saturating so a press longer than TIMEOUT cannot wrap the idle count.
      if (mode_q == MODE_OFF || btn_rise)
        idle_cnt_q <= '0;
      else if (idle_cnt_q != IDLE_MAX)
        idle_cnt_q <= idle_cnt_q + IDLE_W'(1);

      if (pressed_q && hold_cnt_q != HOLD_MAX)
        hold_cnt_q <= hold_cnt_q + HOLD_W'(1);

      if (btn_rise) begin
        pressed_q   <= 1'b1;
        hold_cnt_q  <= '0;
        long_flag_q <= 1'b0;
      end else if (long_trig) begin
        mode_q       <= MODE_OFF;
        long_press_q <= 1'b1;
        long_flag_q  <= 1'b1;
        idle_cnt_q   <= '0;
        if (btn_fall)
          pressed_q <= 1'b0;
      end else if (pressed_q && btn_fall) begin
        pressed_q <= 1'b0;
        if (!long_flag_q) begin
          mode_q     <= mode_adv_d;
          idle_cnt_q <= '0;
          if (mode_adv_d == MODE_BLINK)
            blink_cnt_q <= '0;
        end
      end else if (timeout_hit) begin
        mode_q     <= MODE_OFF;
        idle_cnt_q <= '0;
      end
    end
  end

  // Duty is taken from its register so led depends on flops only.
  always_comb begin
    led = 1'b0;
    case (mode_q)
      MODE_OFF:   led = 1'b0;
      MODE_ON:    led = 1'b1;
      MODE_BLINK: led = blink_cnt_q[BLINK_W-1];
      MODE_DIM:   led = (pwm_cnt_q < duty_q);
      default:    led = 1'b0;
    endcase
  end

  assign mode       = mode_q;
  assign long_press = long_press_q;

endmodule

// File: tb/tb_bikelight_ctrl.sv
// Directed bench for bikelight_ctrl at default parameters.
module tb_bikelight_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_rise = 1'b0;
  logic       btn_fall = 1'b0;
  logic [1:0] dim_duty = 2'd3;
  logic       led;
  logic [1:0] mode;
  logic       long_press;

  int total = 0;
  int bad = 0;
  int pwm_m = 0;

  bikelight_ctrl #(.LONG_T(16), .TIMEOUT(1024), .BLINK_W(4), .PWM_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .btn_rise(btn_rise), .btn_fall(btn_fall),
    .dim_duty(dim_duty), .led(led), .mode(mode), .long_press(long_press)
  );

  always #5 clk = ~clk;

  // Free-running PWM phase reference: zero on reset edges, +1 mod 4 otherwise.
  always @(posedge clk) begin
    if (!rst_n) pwm_m <= 0;
    else        pwm_m <= (pwm_m + 1) % 4;
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int exp_before, input int exp_after);
    btn_rise = 1'b1;
    tick();
    btn_rise = 1'b0;
    repeat (3) tick();
    chk("press_pre", mode, exp_before);
    btn_fall = 1'b1;
    tick();
    btn_fall = 1'b0;
    chk("press_post", mode, exp_after);
    $display("press: mode %0d -> %0d", exp_before, mode);
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_mode", mode, 0);
    chk("rst_led", led, 0);
    chk("rst_long", long_press, 0);
    rst_n = 1'b1;
    tick();

    // Mode ring
    press(0, 1);
    chk("on_led", led, 1);
    press(1, 2);
    press(2, 3);
    press(3, 0);
    chk("off_led", led, 0);

    // Stray release with no press in progress
    btn_fall = 1'b1;
    tick();
    btn_fall = 1'b0;
    chk("stray_fall", mode, 0);

    // Long press from ON
    press(0, 1);
    btn_rise = 1'b1;
    tick();
    btn_rise = 1'b0;
    repeat (15) tick();
    chk("long_pre_pulse", long_press, 0);
    chk("long_pre_mode", mode, 1);
    tick();
    chk("long_pulse", long_press, 1);
    chk("long_mode", mode, 0);
    tick();
    chk("long_pulse_end", long_press, 0);
    repeat (3) tick();
    btn_fall = 1'b1;
    tick();
    btn_fall = 1'b0;
    chk("long_fall_mode", mode, 0);
    $display("long press: pulse seen, mode=%0d after release", mode);

    // Idle timeout in ON
    press(0, 1);
    repeat (1023) tick();
    chk("to_pre", mode, 1);
    tick();
    chk("to_off", mode, 0);
    $display("timeout: mode=%0d after 1024 idle cycles", mode);

    // Press at cycle 1000 restarts the count
    press(0, 1);
    repeat (1000) tick();
    press(1, 2);
    repeat (1022) tick();
    chk("restart_hold1", mode, 2);
    tick();
    chk("restart_hold2", mode, 2);
    tick();
    chk("restart_off", mode, 0);
    $display("restart: mode=%0d after renewed timeout", mode);

    // Blink waveform from entry
    press(0, 1);
    press(1, 2);
    for (int k = 0; k < 32; k++) begin
      chk("blink_led", led, ((k % 16) >= 8) ? 1 : 0);
      tick();
    end
    $display("blink: 32 cycles checked");

    // Dim PWM, duty 3 then 0
    press(2, 3);
    for (int k = 0; k < 8; k++) begin
      chk("dim3_led", led, (pwm_m < 3) ? 1 : 0);
      tick();
    end
    dim_duty = 2'd0;
    tick();
    for (int k = 0; k < 8; k++) begin
      chk("dim0_led", led, 0);
      tick();
    end
    $display("dim: duty 3 and 0 checked");

    // Reset in the middle of a press
    btn_rise = 1'b1;
    tick();
    btn_rise = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_mode", mode, 0);
    chk("midrst_led", led, 0);
    chk("midrst_long", long_press, 0);
    rst_n = 1'b1;
    btn_fall = 1'b1;
    tick();
    btn_fall = 1'b0;
    chk("midrst_fall", mode, 0);

    // Rise during reset is discarded
    rst_n = 1'b0;
    btn_rise = 1'b1;
    tick();
    rst_n = 1'b1;
    btn_rise = 1'b0;
    btn_fall = 1'b1;
    tick();
    btn_fall = 1'b0;
    chk("rst_rise_ignored", mode, 0);
    $display("reset mid-press: mode=%0d", mode);

    // Simultaneous rise and fall: rise wins, later fall is the short press
    btn_rise = 1'b1;
    btn_fall = 1'b1;
    tick();
    btn_rise = 1'b0;
    btn_fall = 1'b0;
    chk("simul_noadv", mode, 0);
    repeat (2) tick();
    btn_fall = 1'b1;
    tick();
    btn_fall = 1'b0;
    chk("simul_then_fall", mode, 1);

    // Release coinciding with the long-press trigger
    btn_rise = 1'b1;
    tick();
    btn_rise = 1'b0;
    repeat (15) tick();
    btn_fall = 1'b1;
    tick();
    btn_fall = 1'b0;
    chk("coinc_mode", mode, 0);
    chk("coinc_pulse", long_press, 1);
    tick();
    chk("coinc_pulse_end", long_press, 0);
    press(0, 1);
    $display("long/short coincidence: mode=%0d", mode);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
